// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e : FSM state encoding (FETCH_RUN, FETCH_HALTED)
//   - HALT_OPCODE   : top nibble that marks a halt instruction
//   - INST_W        : instruction width in bits
//   - FETCH_PC_W    : width of the PC field stored in the IF/ID register
//   - PERF_CNT_W    : width of the performance counters
//   - if_id_t       : packed IF/ID pipeline register (valid, inst, pc)
//   - is_halt()     : halt-opcode decode helper
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INST_W     = 16;
    localparam int FETCH_PC_W = 16;
    localparam int PERF_CNT_W = 16;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [0:0] {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic                  valid;
        logic [INST_W-1:0]     inst;
        logic [FETCH_PC_W-1:0] pc;
    } if_id_t;

    function automatic logic is_halt(input logic [3:0] opcode);
        return (opcode == HALT_OPCODE);
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// ----------------------------------------------------------------------------
// fetch_perf_cnt
// Fetch performance counters, instantiated only when FETCH_PERF_CNT_EN is
// defined. Both counters wrap and clear on the synchronous reset.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   fetch_evt  : one valid IF/ID capture on this edge
//   stall_evt  : stall seen while the fetch FSM is running
//   fetch_cnt  : number of valid captures
//   stall_cnt  : number of stalled edges in RUN
// ----------------------------------------------------------------------------
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_evt,
    input  logic                  stall_evt,
    output logic [PERF_CNT_W-1:0] fetch_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt
);

    logic [PERF_CNT_W-1:0] fetch_cnt_r;
    logic [PERF_CNT_W-1:0] stall_cnt_r;

    // Event counters; natural wrap on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_r <= {PERF_CNT_W{1'b0}};
            stall_cnt_r <= {PERF_CNT_W{1'b0}};
        end else begin
            if (fetch_evt) begin
                fetch_cnt_r <= fetch_cnt_r + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
            end
            if (stall_evt) begin
                stall_cnt_r <= stall_cnt_r + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign fetch_cnt = fetch_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Drives the byte address `pc` into a combinational
// instruction memory, captures the returned nibbles {one,two,three,four} into
// the IF/ID register and advances by 2 each cycle. Handles stall, branch
// redirect, halt opcode (top nibble 4'hF) and out-of-range fetch addresses.
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters; when
// undefined fetch_cnt/stall_cnt are tied to 0).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   stall                         : decode back-pressure, hold everything
//   redirect, redirect_pc         : taken branch/jump and its byte target
//   pc                            : fetch address to instruction memory
//   one, two, three, four         : nibbles of mem[pc] and mem[pc+1]
//   if_id_valid/inst/pc           : IF/ID pipeline register
//   halted                        : fetch FSM is in HALTED
//   fault                         : sticky out-of-range indication
//   fetch_cnt, stall_cnt          : performance counters
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
    parameter int              MEM_BYTES = 52
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic [PC_W-1:0]       pc,
    input  logic [3:0]            one,
    input  logic [3:0]            two,
    input  logic [3:0]            three,
    input  logic [3:0]            four,
    output logic                  if_id_valid,
    output logic [INST_W-1:0]     if_id_inst,
    output logic [PC_W-1:0]       if_id_pc,
    output logic                  halted,
    output logic                  fault,
    output logic [PERF_CNT_W-1:0] fetch_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt
);

    // Last address whose two bytes both lie inside the memory.
    localparam logic [PC_W-1:0] LAST_PC  = PC_W'(MEM_BYTES - 2);
    // Clears bit 0 so a redirect always lands on an instruction boundary.
    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-1){1'b1}}, 1'b0};

    fetch_state_e    state_r, state_s;
    logic [PC_W-1:0] pc_r, pc_s;
    if_id_t          if_id_r, if_id_s;
    logic            fault_r, fault_s;

    // Next-state logic: redirect beats stall, stall beats halt/fault/normal.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        if_id_s = if_id_r;
        fault_s = fault_r;
        if (redirect) begin
            pc_s          = redirect_pc & ALIGN_MASK;
            if_id_s.valid = 1'b0;
            state_s       = FETCH_RUN;
        end else if (stall) begin
            // Everything holds; defaults above already keep current values.
            state_s = state_r;
        end else begin
            case (state_r)
                FETCH_RUN: begin
                    if (pc_r > LAST_PC) begin
                        if_id_s.valid = 1'b0;
                        state_s       = FETCH_HALTED;
                        fault_s       = 1'b1;
                    end else begin
                        if_id_s.valid = 1'b1;
                        if_id_s.inst  = {one, two, three, four};
                        if_id_s.pc    = FETCH_PC_W'(pc_r);
                        if (is_halt(one)) begin
                            // Halt instruction is delivered; PC parks on it.
                            state_s = FETCH_HALTED;
                        end else begin
                            pc_s = pc_r + PC_W'(2);
                        end
                    end
                end
                FETCH_HALTED: begin
                    if_id_s.valid = 1'b0;
                end
                default: begin
                    if_id_s.valid = 1'b0;
                    state_s       = FETCH_HALTED;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH_RUN;
            pc_r    <= RESET_PC;
            if_id_r <= '0;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            if_id_r <= if_id_s;
            fault_r <= fault_s;
        end
    end

    assign pc          = pc_r;
    assign if_id_valid = if_id_r.valid;
    assign if_id_inst  = if_id_r.inst;
    assign if_id_pc    = if_id_r.pc[PC_W-1:0];
    assign halted      = (state_r == FETCH_HALTED);
    assign fault       = fault_r;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_evt_s;
    logic stall_evt_s;

    // A capture happens exactly on an unstalled, unredirected in-range RUN edge.
    assign fetch_evt_s = !redirect && !stall && (state_r == FETCH_RUN) && (pc_r <= LAST_PC);
    assign stall_evt_s = stall && (state_r == FETCH_RUN);

    fetch_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .fetch_evt (fetch_evt_s),
        .stall_evt (stall_evt_s),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    assign fetch_cnt = 16'h0000;
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the byte address into the instruction memory and consumes the four returned nibbles (`one`, `two`, `three`, `four`). It owns the program counter, registers each 16-bit instruction into the IF/ID pipeline register, and handles stall, branch redirect, halt-opcode detection and out-of-range addresses. It sits between the instruction memory and the decode stage.

## Interface
- `PC_W`, 16, program-counter width in bits.
- `RESET_PC`, 16'h0000, PC value loaded by reset; must be even.
- `MEM_BYTES`, 52, instruction memory depth in bytes; the last legal fetch address is `MEM_BYTES-2`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: decode back-pressure; hold PC and IF/ID.
- `redirect` input 1: branch/jump taken; load `redirect_pc`.
- `redirect_pc` input PC_W: redirect target byte address.
- `pc` output PC_W: fetch address to instruction memory.
- `one`, `two`, `three`, `four` input 4 each: nibbles of `mem[pc]` (high, low) and `mem[pc+1]` (high, low).
- `if_id_valid` output 1: IF/ID holds a valid instruction.
- `if_id_inst` output 16: `{one,two,three,four}` as captured.
- `if_id_pc` output PC_W: address of the captured instruction.
- `halted` output 1: fetch has stopped.
- `fault` output 1: sticky; set when the PC went out of range.
- `fetch_cnt`, `stall_cnt` output 16 each: performance counters (see Configuration).

## Operation
- FSM states are RUN and HALTED. Reset puts the FSM in RUN with `pc=RESET_PC` and every output at 0.
- Per-edge priority: `rst` > `redirect` > `stall` > halt/fault > normal.
- RUN, normal (no redirect, no stall, `pc <= MEM_BYTES-2`):
  - IF/ID captures `{one,two,three,four}`, `pc`, and valid=1.
  - `pc <= pc+2`, wrapping modulo 2^PC_W.
- Halt opcode: if `one==4'hF` in RUN with no redirect and no stall, the instruction is captured valid. Then the FSM enters HALTED, `pc` holds, and `halted=1`.
- Out of range: if `pc > MEM_BYTES-2` in RUN with no stall and no redirect:
  - no capture is made and `if_id_valid` goes to 0;
  - the FSM enters HALTED;
  - `fault` is set to 1 and stays set until `rst`.
- HALTED: `pc` and `if_id_inst`/`if_id_pc` hold, and `if_id_valid` is 0 from the edge after the halt instruction was captured.
- Stall: `pc`, the IF/ID register and the FSM state all hold. A stall in HALTED has no effect.
- Redirect (in any state, even when stall is asserted):
  - `pc <= {redirect_pc[PC_W-1:1],1'b0}`, so bit 0 is forced to 0;
  - `if_id_valid <= 0` (flush);
  - FSM goes to RUN and `halted` clears.
  - `fault` is not cleared.

## Timing
- The memory read path is combinational. An instruction at `pc` is visible in IF/ID one edge later (latency 1), giving a throughput of one instruction per cycle.
- After a redirect the first target instruction appears in IF/ID 2 edges after the redirect edge: one edge to load the PC, one to capture.
- After reset the first valid capture occurs on the first edge with `rst=0`.
- `halted` and `fault` are registered and assert on the same edge as the state change.

## Configuration
- `FETCH_PERF_CNT_EN`:
  - Defined: `fetch_cnt` increments on every valid capture and `stall_cnt` on every edge with `stall=1` in RUN. Both are 16-bit, wrap, and reset to 0.
  - Undefined: the counter logic is omitted and both ports are tied to 0.

## Structure
- Shared package `fetch_pkg` holds:
  - the FSM state enum (`FETCH_RUN`, `FETCH_HALTED`);
  - `HALT_OPCODE = 4'hF`;
  - `INST_W = 16`;
  - a packed IF/ID struct (`valid`, `inst`, `pc`).
- Sub-module `fetch_perf_cnt` holds both counters and is instantiated only under `FETCH_PERF_CNT_EN`.

## Test plan
- Reset, then run with a model memory returning bytes 01,2F,01,2E,…: IF/ID shows 0x012F@pc0, then 0x012E@pc2, `fetch_cnt=2`.
- Assert `stall` for 3 cycles at pc=4: `pc`, `if_id_inst=0x012E` and `if_id_pc=2` hold; `stall_cnt=3`; fetch resumes with 0x034C@4.
- `redirect=1` with `redirect_pc=0x0025` while `stall=1`: `pc=0x0024` next edge, `if_id_valid=0`, 0x8890@0x24 captured one edge later.
- Run to pc=50 (byte F0): 0xF000 is captured valid, `halted=1`, and `pc` stays at 50 for 10 cycles with `if_id_valid=0`.
- Redirect to 0x0040 with `MEM_BYTES=52`: the next edge sets `fault=1`, `halted=1` and `if_id_valid=0`. A later redirect to 0 resumes fetch while `fault` stays 1 until `rst`.
- Assert `rst` mid-run at pc=20: next edge `pc=0`, FSM in RUN, and all outputs including `fault` and the counters are 0.
